// File: rtl/digit_seq_pkg.sv
// Shared constants for the digit sequencer: seven-segment patterns (gfedcba, active-high)
// and the power-on digit sequence.
package digit_seq_pkg;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

    // Slot i lives in nibble i: slots 0..4 = 3,1,4,5,8, remaining slots 0.
    localparam logic [15:0][3:0] RESET_SEQ = 64'h0000_0000_0008_5413;

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SEG_0;
        case (digit)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_0;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational hex digit to seven-segment encoder (active-high, bit0 = a).
module seg7_encode
    import digit_seq_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_of(digit);
    end

endmodule

// File: rtl/digit_sequencer.sv
// Loadable hex digit sequence with a wrapping position pointer, advanced by step edges or a
// prescaled auto-tick, driving a window of seven-segment displays from the current position.
module digit_sequencer
    import digit_seq_pkg::*;
#(
    parameter  int unsigned DEPTH    = 5,
    parameter  int unsigned NUM_HEX  = 1,
    parameter  int unsigned TICK_DIV = 25_000_000,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = $clog2(TICK_DIV)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step,
    input  logic                 dir,
    input  logic                 auto,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [3:0]           wr_data,
    output logic [7*NUM_HEX-1:0] hex,
    output logic [AW-1:0]        pos,
    output logic                 wrap
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [3:0]    seq_q [DEPTH];
    logic [AW-1:0] pos_q, pos_d;
    logic          wrap_q, wrap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_q;
    logic          step_rise;
    logic          tick;
    logic          advance;

    always_comb begin
        step_rise = step & ~step_q;
        tick      = auto && (cnt_q == CNT_MAX);
        // A coincident edge and tick collapse into a single advance.
        advance   = step_rise | tick;

        cnt_d = '0;
        if (auto && !tick) begin
            cnt_d = cnt_q + 1'b1;
        end

        pos_d  = pos_q;
        wrap_d = 1'b0;
        if (advance) begin
            if (dir) begin
                if (pos_q == '0) begin
                    pos_d  = LAST;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q - 1'b1;
                end
            end else begin
                if (pos_q == LAST) begin
                    pos_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end
        end
    end

    // step_q tracks step through reset so a key held across reset never counts as an edge.
    always_ff @(posedge clk) begin
        step_q <= step;
        if (rst) begin
            pos_q  <= '0;
            wrap_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pos_q  <= pos_d;
            wrap_q <= wrap_d;
            cnt_q  <= cnt_d;
        end
    end

    // Out-of-range addresses match no slot, so they are dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                seq_q[i] <= RESET_SEQ[i];
            end else if (wr_en && (wr_addr == AW'(i))) begin
                seq_q[i] <= wr_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_HEX; k++) begin : g_disp
        logic [AW:0]   sum;
        logic [AW-1:0] idx;

        // pos + k < 2*DEPTH, so one conditional subtract gives the modulo.
        assign sum = {1'b0, pos_q} + (AW+1)'(k);
        assign idx = AW'((sum >= DEPTH_W) ? (sum - DEPTH_W) : sum);

        seg7_encode u_seg (
            .digit (seq_q[idx]),
            .seg   (hex[7*k +: 7])
        );
    end

    assign pos  = pos_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_digit_sequencer.sv
// Scoreboard bench for digit_sequencer: a driver predicts each cycle's outputs from a
// behavioural model and queues them; a monitor compares after every clock edge.
module tb_digit_sequencer;

    localparam int DEPTH    = 5;
    localparam int NUM_HEX  = 3;
    localparam int TICK_DIV = 4;
    localparam int AW       = $clog2(DEPTH);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 step = 1'b0;
    logic                 dir = 1'b0;
    logic                 auto = 1'b0;
    logic                 wr_en = 1'b0;
    logic [AW-1:0]        wr_addr = '0;
    logic [3:0]           wr_data = '0;
    logic [7*NUM_HEX-1:0] hex;
    logic [AW-1:0]        pos;
    logic                 wrap;

    always #5 clk = ~clk;

    digit_sequencer #(
        .DEPTH    (DEPTH),
        .NUM_HEX  (NUM_HEX),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .step    (step),
        .dir     (dir),
        .auto    (auto),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .hex     (hex),
        .pos     (pos),
        .wrap    (wrap)
    );

    typedef struct packed {
        logic [AW-1:0]        pos;
        logic                 wrap;
        logic [7*NUM_HEX-1:0] hex;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };
    int rst_seq [5] = '{3, 1, 4, 5, 8};

    // Behavioural model state
    int m_seq [DEPTH];
    int m_pos = 0;
    int m_cnt = 0;
    bit m_wrap = 1'b0;
    bit m_step_prev = 1'b0;

    function automatic exp_t snapshot();
        exp_t e;
        e.pos  = AW'(m_pos);
        e.wrap = m_wrap;
        e.hex  = '0;
        for (int k = 0; k < NUM_HEX; k++) begin
            e.hex[7*k +: 7] = seg_tab[m_seq[(m_pos + k) % DEPTH]];
        end
        return e;
    endfunction

    task automatic drive(input bit r, input bit s, input bit d, input bit a,
                         input bit we, input int wa, input int wd);
        bit rise;
        bit tick;
        @(negedge clk);
        rst     = r;
        step    = s;
        dir     = d;
        auto    = a;
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = 4'(wd);
        if (r) begin
            m_pos  = 0;
            m_wrap = 1'b0;
            m_cnt  = 0;
            for (int i = 0; i < DEPTH; i++) m_seq[i] = (i < 5) ? rst_seq[i] : 0;
        end else begin
            rise  = s && !m_step_prev;
            tick  = a && (m_cnt == TICK_DIV - 1);
            m_cnt = a ? (tick ? 0 : m_cnt + 1) : 0;
            if (rise || tick) begin
                if (d) begin
                    m_wrap = (m_pos == 0);
                    m_pos  = (m_pos + DEPTH - 1) % DEPTH;
                end else begin
                    m_wrap = (m_pos == DEPTH - 1);
                    m_pos  = (m_pos + 1) % DEPTH;
                end
            end else begin
                m_wrap = 1'b0;
            end
            if (we && wa < DEPTH) m_seq[wa] = wd;
        end
        m_step_prev = s;
        sb.push_back(snapshot());
    endtask

    task automatic idle(input int n, input bit a);
        for (int i = 0; i < n; i++) drive(0, 0, 0, a, 0, 0, 0);
    endtask

    task automatic pulse(input bit d);
        drive(0, 1, d, 0, 0, 0, 0);
        drive(0, 0, d, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents pos/wrap/hex; compare against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pos", 32'(pos), 32'(e.pos));
                chk("wrap", 32'(wrap), 32'(e.wrap));
                chk("hex", 32'(hex), 32'(e.hex));
            end
        end
    end

    initial begin
        bit a_rand;
        a_rand = 1'b0;

        // Reset, then forward through the whole sequence and wrap.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) pulse(0);

        // Backward from reset wraps to the last slot.
        drive(1, 0, 0, 0, 0, 0, 0);
        pulse(1);
        pulse(1);

        // Step held across reset deassert: no advance.
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Auto advance, coincident edge+tick, then auto dropped mid-count.
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(9, 1);
        idle(2, 1);
        drive(0, 1, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        idle(2, 1);
        idle(1, 0);
        idle(6, 1);

        // Writes: in-range at pos 2, out-of-range ignored, window wrap at pos 4.
        drive(1, 0, 0, 0, 0, 0, 0);
        pulse(0);
        pulse(0);
        drive(0, 0, 0, 0, 1, 2, 'hA);
        drive(0, 0, 0, 0, 1, 7, 'h6);
        pulse(0);
        drive(0, 1, 0, 0, 1, 0, 'hE);
        drive(0, 0, 0, 0, 0, 0, 0);
        pulse(0);
        pulse(0);
        pulse(0);
        drive(1, 0, 0, 1, 0, 0, 0);
        idle(2, 0);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) a_rand = ~a_rand;
            drive(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), a_rand,
                  ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)));
        end

        idle(2, 0);
        @(posedge clk);
        #2;
        chk("drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
